// File: rtl/debug_probe_pkg.sv
// Shared types for the OSD probe capture block: operating modes and trigger FSM states.
package debug_probe_pkg;

  typedef enum logic [1:0] {
    LIVE     = 2'b00,
    PERIODIC = 2'b01,
    TRIGGER  = 2'b10,
    FROZEN   = 2'b11
  } probe_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HELD
  } cap_state_t;

  localparam int unsigned HIT_W   = 16;
  localparam logic [HIT_W-1:0] HIT_MAX = '1;

endpackage

// File: rtl/probe_tick_gen.sv
// Free-running refresh divider: one-cycle tick every CLK_HZ/UPDATE_HZ clocks.
module probe_tick_gen #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned UPDATE_HZ = 10
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / UPDATE_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        cnt <= CW'(DIV - 1);
    else if (cnt == '0)  cnt <= CW'(DIV - 1);
    else                 cnt <= cnt - 1'b1;
  end

  always_comb tick = (cnt == '0);

endmodule

// File: rtl/debug_probe_capture.sv
// Multi-channel probe sampler for the OSD overlay: live, periodic, masked-trigger
// and frozen capture with per-channel change flags and a saturating hit counter.
module debug_probe_capture
  import debug_probe_pkg::*;
#(
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned UPDATE_HZ = 10,
  localparam int unsigned CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] probe_in,
  input  logic [1:0]                mode,
  input  logic                      arm,
  input  logic [CHW-1:0]            trig_chan,
  input  logic [WIDTH-1:0]          trig_value,
  input  logic [WIDTH-1:0]          trig_mask,
  output logic [CHANNELS*WIDTH-1:0] probe_out,
  output logic                      tick,
  output logic                      armed,
  output logic                      triggered,
  output logic [CHANNELS-1:0]       changed,
  output logic [HIT_W-1:0]          hit_count
);

  probe_mode_t      mode_e;
  cap_state_t       state, state_nx;
  logic [WIDTH-1:0] sel;
  logic             match, match_r, match_d;
  logic             arm_eff, capture, load;
  logic [HIT_W-1:0] hit_q;

  probe_tick_gen #(.CLK_HZ(CLK_HZ), .UPDATE_HZ(UPDATE_HZ)) u_tick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign mode_e = probe_mode_t'(mode);

  // A trig_chan with no matching channel leaves match low.
  always_comb begin
    sel   = '0;
    match = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (trig_chan == CHW'(k)) begin
        sel   = probe_in[k*WIDTH +: WIDTH];
        match = ((sel ^ trig_value) & trig_mask) == '0;
      end
    end
  end

  always_comb begin
    arm_eff  = arm && (mode_e == TRIGGER);
    capture  = (mode_e == TRIGGER) && (state == ARMED) && match && !arm;
    state_nx = state;
    if (mode_e != TRIGGER)                  state_nx = IDLE;
    else if (arm)                           state_nx = ARMED;
    else if ((state == ARMED) && match)     state_nx = HELD;
    unique case (mode_e)
      LIVE:     load = 1'b1;
      PERIODIC: load = tick;
      TRIGGER:  load = capture;
      default:  load = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      triggered <= 1'b0;
      match_r   <= 1'b0;
      match_d   <= 1'b0;
      hit_q     <= '0;
    end else begin
      state     <= state_nx;
      armed     <= (state_nx == ARMED);
      triggered <= (state_nx == HELD);
      match_r   <= match;
      match_d   <= match_r;
      if (arm_eff)                                  hit_q <= '0;
      else if (match_r && !match_d && hit_q != HIT_MAX) hit_q <= hit_q + 1'b1;
    end
  end

  assign hit_count = hit_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [WIDTH-1:0] held;
    logic             chg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        held <= '0;
        chg  <= 1'b0;
      end else if (load) begin
        held <= probe_in[k*WIDTH +: WIDTH];
        chg  <= (probe_in[k*WIDTH +: WIDTH] != held);
      end
    end

    assign probe_out[k*WIDTH +: WIDTH] = held;
    assign changed[k]                  = chg;
  end

endmodule

// File: tb/tb_debug_probe_capture.sv
// Randomised scoreboard bench for debug_probe_capture with a spec-level reference model.
module tb_debug_probe_capture;

  localparam int unsigned CH  = 8;
  localparam int unsigned W   = 16;
  localparam int unsigned DIV = 10;
  localparam int unsigned CHW = 3;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic [CH*W-1:0]   probe_in = '0;
  logic [1:0]        mode = 2'b00;
  logic              arm = 1'b0;
  logic [CHW-1:0]    trig_chan = '0;
  logic [W-1:0]      trig_value = '0;
  logic [W-1:0]      trig_mask = '0;
  logic [CH*W-1:0]   probe_out;
  logic              tick, armed, triggered;
  logic [CH-1:0]     changed;
  logic [15:0]       hit_count;

  debug_probe_capture #(.CHANNELS(CH), .WIDTH(W), .CLK_HZ(100), .UPDATE_HZ(10)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .probe_in   (probe_in),
    .mode       (mode),
    .arm        (arm),
    .trig_chan  (trig_chan),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .probe_out  (probe_out),
    .tick       (tick),
    .armed      (armed),
    .triggered  (triggered),
    .changed    (changed),
    .hit_count  (hit_count)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [CH*W-1:0] probe;
    logic            tick, armed, triggered;
    logic [CH-1:0]   changed;
    logic [15:0]     hit;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 waiting for match, 2 holding a capture.
  logic [CH*W-1:0] m_probe;
  logic [CH-1:0]   m_changed;
  int              m_st;
  logic [15:0]     m_hit;
  logic            mh1, mh2;
  int unsigned     cyc;
  int              preload_seq = 0, preload_seen = 0;
  logic [15:0]     preload_val = '0;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_probe = '0; m_changed = '0; m_st = 0; m_hit = '0;
      mh1 = 1'b0; mh2 = 1'b0; cyc = 0;
      q.delete();
    end else begin
      logic        tick_now, mt, cap, ld;
      logic [W-1:0] chunk;
      exp_t        e;
      if (preload_seq != preload_seen) begin
        preload_seen = preload_seq;
        m_hit = preload_val;
      end
      tick_now = ((cyc % DIV) == DIV - 1);
      mt = 1'b0;
      if (int'(trig_chan) < CH) begin
        chunk = probe_in[int'(trig_chan)*W +: W];
        mt = (((chunk ^ trig_value) & trig_mask) == '0);
      end
      cap = (mode == 2'b10) && (m_st == 1) && mt && !arm;
      ld  = (mode == 2'b00) || (mode == 2'b01 && tick_now) || cap;
      if (ld) begin
        for (int k = 0; k < CH; k++)
          m_changed[k] = (probe_in[k*W +: W] != m_probe[k*W +: W]);
        m_probe = probe_in;
      end
      if (mode != 2'b10) m_st = 0;
      else if (arm)      m_st = 1;
      else if (cap)      m_st = 2;
      if (mode == 2'b10 && arm)                 m_hit = '0;
      else if (mh1 && !mh2 && m_hit != 16'hFFFF) m_hit = m_hit + 16'd1;
      mh2 = mh1;
      mh1 = mt;
      cyc++;
      e.probe = m_probe; e.changed = m_changed; e.hit = m_hit;
      e.armed = (m_st == 1); e.triggered = (m_st == 2);
      e.tick  = ((cyc % DIV) == DIV - 1);
      q.push_back(e);
    end
  end

  always @(negedge clk_sys) begin
    if (reset_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("probe_out", 128'(probe_out), 128'(e.probe));
      check("tick",      128'(tick),      128'(e.tick));
      check("armed",     128'(armed),     128'(e.armed));
      check("triggered", 128'(triggered), 128'(e.triggered));
      check("changed",   128'(changed),   128'(e.changed));
      check("hit_count", 128'(hit_count), 128'(e.hit));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] v);
    probe_in[k*W +: W] = v;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk_sys);
    arm = 1'b0;
  endtask

  function automatic logic [CH*W-1:0] rand_vec();
    logic [CH*W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v;
  endfunction

  initial begin
    int first_tick;
    int tc;

    // Reset held with live probe data: everything stays at zero.
    probe_in = rand_vec();
    cycles(3);
    check("rst_probe_out", 128'(probe_out), 128'(0));
    check("rst_flags", 128'({tick, armed, triggered, changed}), 128'(0));
    check("rst_hit", 128'(hit_count), 128'(0));
    mode = 2'b01;
    probe_in = '0;
    reset_n = 1'b1;

    first_tick = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_sys);
      if (tick && first_tick < 0) first_tick = i;
    end
    check("first_tick_cycle", 128'(first_tick), 128'(9));

    // Periodic refresh with a channel change between ticks.
    set_ch(0, 16'h1234);
    cycles(12);
    set_ch(0, 16'h5678);
    cycles(25);

    // Masked trigger on channel 1.
    mode = 2'b10; trig_chan = 3'd1; trig_value = 16'hAB00; trig_mask = 16'hFF00;
    set_ch(1, 16'hAA12);
    cycles(3);
    pulse_arm();
    cycles(5);
    check("t3_no_capture", 128'(triggered), 128'(0));
    set_ch(1, 16'hAB34);
    set_ch(3, 16'hC0DE);
    cycles(4);
    check("t3_triggered", 128'(triggered), 128'(1));
    check("t3_hit", 128'(hit_count), 128'(1));
    check("t3_ch1", 128'(probe_out[1*W +: W]), 128'(16'hAB34));
    set_ch(1, 16'hAB99);
    cycles(4);
    check("t3_held_ch1", 128'(probe_out[1*W +: W]), 128'(16'hAB34));

    // Arm while matching: arm cycle only re-arms, capture follows.
    set_ch(1, 16'hAB55);
    cycles(2);
    arm = 1'b1;
    @(negedge clk_sys);
    arm = 1'b0;
    check("t4_armed", 128'(armed), 128'(1));
    check("t4_no_capture", 128'(probe_out[1*W +: W]), 128'(16'hAB34));
    @(negedge clk_sys);
    check("t4_triggered", 128'(triggered), 128'(1));
    check("t4_capture", 128'(probe_out[1*W +: W]), 128'(16'hAB55));

    // Live, frozen, and leaving trigger mode while armed.
    mode = 2'b00;
    for (int i = 0; i < 8; i++) begin
      probe_in = rand_vec();
      @(negedge clk_sys);
    end
    mode = 2'b11;
    for (int i = 0; i < 35; i++) begin
      probe_in = rand_vec();
      @(negedge clk_sys);
    end
    mode = 2'b10;
    set_ch(1, 16'h0000);
    pulse_arm();
    check("t5_armed", 128'(armed), 128'(1));
    mode = 2'b00;
    @(negedge clk_sys);
    check("t5_left_trigger", 128'(armed), 128'(0));

    // Saturation of hit_count near the top of its range.
    mode = 2'b10;
    cycles(3);
    #2;
    force dut.hit_q = 16'hFFFC;
    preload_val = 16'hFFFC;
    preload_seq++;
    #1;
    release dut.hit_q;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys); set_ch(1, 16'hAB01);
      @(negedge clk_sys); set_ch(1, 16'h0000);
    end
    cycles(3);
    check("t6_saturated", 128'(hit_count), 128'(16'hFFFF));
    pulse_arm();
    check("t6_cleared", 128'(hit_count), 128'(0));

    // Randomised mixed operation.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_sys);
      arm = 1'b0;
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(31) == 0) begin
        trig_chan  = CHW'($urandom_range(CH - 1));
        trig_value = W'($urandom);
        trig_mask  = W'($urandom & $urandom & $urandom);
      end
      tc = int'(trig_chan);
      case ($urandom_range(3))
        0: probe_in = rand_vec();
        1: set_ch(tc, trig_value | (W'($urandom) & ~trig_mask));
        2: set_ch(tc, W'($urandom));
        default: ;
      endcase
      if (mode == 2'b10 && $urandom_range(7) == 0) arm = 1'b1;
    end
    @(negedge clk_sys);
    arm = 1'b0;

    // Asynchronous reset mid-operation.
    mode = 2'b00;
    probe_in = rand_vec();
    cycles(3);
    @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_probe", 128'(probe_out), 128'(0));
    check("async_rst_flags", 128'({tick, armed, triggered, changed, hit_count}), 128'(0));
    @(negedge clk_sys);
    reset_n = 1'b1;
    cycles(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
